// File: rtl/com_dispatcher.sv
// Command dispatcher: fetches command words from the FIFO, expands LOAD/COMPUTE/STORE
// into address bursts on a valid/ready port, and replays the list on ITER_END.
module com_dispatcher #(
  parameter  int OP_W   = 3,
  parameter  int ADDR_W = 10,
  parameter  int LEN_W  = 8,
  parameter  int ITER_W = 8,
  localparam int CMD_W  = OP_W + ADDR_W + LEN_W
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  output logic              fifo_rinc,
  input  logic [CMD_W-1:0]  fifo_rdata,
  output logic              replay_iter_flag,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [ADDR_W-1:0] iss_addr,
  output logic              iss_last,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_REPLAY, S_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_COMP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ITER  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BAD5  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BAD6  = OP_W'(6);

  state_t              state_reg, state_next;
  logic [OP_W-1:0]     op_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W:0]      beat_reg;
  logic [ITER_W-1:0]   iter_lat_reg;
  logic [ITER_W-1:0]   iter_idx_reg;
  logic                err_reg;

  logic [OP_W-1:0]     rd_op;
  logic [ADDR_W-1:0]   rd_addr;
  logic [LEN_W-1:0]    rd_len;
  logic [ITER_W:0]     iter_inc;
  logic                last_beat;

  assign rd_op     = fifo_rdata[CMD_W-1 -: OP_W];
  assign rd_addr   = fifo_rdata[LEN_W +: ADDR_W];
  assign rd_len    = fifo_rdata[LEN_W-1:0];
  // One bit wider so iter_idx+1 cannot wrap when compared against the latched count
  assign iter_inc  = {1'b0, iter_idx_reg} + (ITER_W+1)'(1);
  assign last_beat = (beat_reg == {1'b0, len_reg});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_WAIT;
      S_WAIT: begin
        case (rd_op)
          OP_NOP, OP_BAD5, OP_BAD6:   state_next = S_FETCH;
          OP_LOAD, OP_COMP, OP_STORE: state_next = S_ISSUE;
          OP_ITER: state_next = (iter_inc < {1'b0, iter_lat_reg}) ? S_REPLAY : S_DONE;
          default:                    state_next = S_DONE;
        endcase
      end
      S_ISSUE:  if (iss_ready && last_beat) state_next = S_FETCH;
      S_REPLAY: state_next = S_FETCH;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_reg     <= '0;
      iter_lat_reg <= '0;
      iter_idx_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            iter_lat_reg <= (iter_count == '0) ? ITER_W'(1) : iter_count;
            iter_idx_reg <= '0;
            err_reg      <= 1'b0;
          end
        end
        S_WAIT: begin
          op_reg   <= rd_op;
          addr_reg <= rd_addr;
          len_reg  <= rd_len;
          beat_reg <= '0;
          if (rd_op == OP_BAD5 || rd_op == OP_BAD6) err_reg <= 1'b1;
        end
        S_ISSUE:  if (iss_ready) beat_reg <= beat_reg + (LEN_W+1)'(1);
        S_REPLAY: iter_idx_reg <= iter_idx_reg + ITER_W'(1);
        default: ;
      endcase
    end
  end

  // Issue fields are gated by valid so they read zero outside a burst
  assign iss_valid        = (state_reg == S_ISSUE);
  assign iss_op           = iss_valid ? op_reg : '0;
  assign iss_addr         = iss_valid ? (addr_reg + ADDR_W'(beat_reg)) : '0;
  assign iss_last         = iss_valid && last_beat;
  assign fifo_rinc        = (state_reg == S_FETCH);
  assign replay_iter_flag = (state_reg == S_REPLAY);
  assign done             = (state_reg == S_DONE);
  assign busy             = (state_reg != S_IDLE);
  assign iter_idx         = iter_idx_reg;
  assign err              = err_reg;

endmodule
